kcpsm6_led_scanner: RTL and testbench

//  Parametrised LED output peripheral on the KCPSM6 I/O bus (port_id/out_port/in_port).

---
 rtl/kcpsm6_led_scanner.sv | 179 +++++++++++++++++
 tb/tb_kcpsm6_led_scanner.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kcpsm6_led_scanner.sv
// rtl/kcpsm6_led_scanner.sv - KCPSM6 LED peripheral with direct, blink and bouncing scan modes.
// Optional PWM brightness gate on register +4 is built when LED_PWM_EN is defined.
module kcpsm6_led_scanner #(
  parameter int         NUM_LEDS      = 4,
  parameter logic [7:0] BASE_ADDR     = 8'h00,
  parameter int         CLKS_PER_UNIT = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          port_id,
  input  logic                write_strobe,
  input  logic [7:0]          out_port,
  input  logic                read_strobe,
  output logic [7:0]          in_port,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                scan_end
);
  localparam int            CW       = $clog2(CLKS_PER_UNIT);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_UNIT - 1);
  localparam logic [2:0]    POS_TOP  = 3'(NUM_LEDS - 1);
  localparam logic [2:0]    POS_NEAR = 3'(NUM_LEDS - 2);

  localparam logic [7:0] ADDR_DATA   = BASE_ADDR;
  localparam logic [7:0] ADDR_CTRL   = BASE_ADDR + 8'd1;
  localparam logic [7:0] ADDR_PERIOD = BASE_ADDR + 8'd2;
  localparam logic [7:0] ADDR_STATUS = BASE_ADDR + 8'd3;
  localparam logic [7:0] ADDR_BRIGHT = BASE_ADDR + 8'd4;

  localparam logic [1:0] MODE_DIRECT = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SCAN   = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  logic [7:0]          data_reg;
  logic [7:0]          period_reg;
  logic [7:0]          period_act;
  logic [7:0]          unit_cnt;
  logic [1:0]          mode;
  logic [CW-1:0]       clk_cnt;
  logic [2:0]          pos;
  logic                dir;
  logic                phase;
  logic                end_flag;
  logic                wr_data;
  logic                wr_ctrl;
  logic                wr_period;
  logic                rd_status;
  logic                unit_tick;
  logic                step_tick;
  logic                end_hit;
  logic                pwm_on;
  logic [7:0]          bright_val;
  logic [7:0]          rd_mux;
  logic [NUM_LEDS-1:0] one_hot;
  logic [NUM_LEDS-1:0] pattern;

  assign wr_data   = write_strobe && (port_id == ADDR_DATA);
  assign wr_ctrl   = write_strobe && (port_id == ADDR_CTRL);
  assign wr_period = write_strobe && (port_id == ADDR_PERIOD);
  assign rd_status = read_strobe && (port_id == ADDR_STATUS);

  assign unit_tick = (clk_cnt == CLK_LAST);
  assign step_tick = unit_tick && (unit_cnt == period_act);
  // A CTRL write in the same cycle restarts the scan, so it must not report an end.
  assign end_hit   = step_tick && !wr_ctrl && (mode == MODE_SCAN) &&
                     (dir ? (pos == 3'd1) : (pos == POS_NEAR));

`ifdef LED_PWM_EN
  logic [7:0] bright_reg;
  logic [7:0] pwm_cnt;
  logic       wr_bright;

  assign wr_bright = write_strobe && (port_id == ADDR_BRIGHT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bright_reg <= 8'hFF;
      pwm_cnt    <= 8'h00;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (wr_bright) bright_reg <= out_port;
    end
  end

  assign pwm_on     = (pwm_cnt < bright_reg);
  assign bright_val = bright_reg;
`else
  assign pwm_on     = 1'b1;
  assign bright_val = 8'h00;
`endif

  always_comb begin
    one_hot = '0;
    for (int i = 0; i < NUM_LEDS; i++) one_hot[i] = (pos == 3'(i));
  end

  always_comb begin
    pattern = '0;
    case (mode)
      MODE_DIRECT: pattern = data_reg[NUM_LEDS-1:0];
      MODE_BLINK:  pattern = phase ? data_reg[NUM_LEDS-1:0] : '0;
      MODE_SCAN:   pattern = one_hot;
      MODE_OFF:    pattern = '0;
      default:     pattern = '0;
    endcase
  end

  always_comb begin
    rd_mux = 8'h00;
    case (port_id)
      ADDR_DATA:   rd_mux = data_reg;
      ADDR_CTRL:   rd_mux = {6'b0, mode};
      ADDR_PERIOD: rd_mux = period_reg;
      ADDR_STATUS: rd_mux = {pos, dir, phase, end_flag, mode};
      ADDR_BRIGHT: rd_mux = bright_val;
      default:     rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg   <= 8'h00;
      period_reg <= 8'h00;
      period_act <= 8'h00;
      unit_cnt   <= 8'h00;
      mode       <= MODE_DIRECT;
      clk_cnt    <= '0;
      pos        <= 3'd0;
      dir        <= 1'b0;
      phase      <= 1'b0;
      end_flag   <= 1'b0;
      scan_end   <= 1'b0;
      led_out    <= '0;
      in_port    <= 8'h00;
    end else begin
      if (wr_data)   data_reg   <= out_port;
      if (wr_period) period_reg <= out_port;

      if (wr_ctrl) begin
        mode       <= out_port[1:0];
        pos        <= 3'd0;
        dir        <= 1'b0;
        phase      <= 1'b0;
        clk_cnt    <= '0;
        unit_cnt   <= 8'h00;
        period_act <= period_reg;
      end else begin
        clk_cnt <= unit_tick ? '0 : clk_cnt + CW'(1);
        if (step_tick) begin
          unit_cnt   <= 8'h00;
          // A PERIOD write only takes hold at a unit-counter wrap.
          period_act <= wr_period ? out_port : period_reg;
        end else if (unit_tick) begin
          unit_cnt <= unit_cnt + 8'd1;
        end
        if (step_tick && mode == MODE_BLINK) phase <= ~phase;
        if (step_tick && mode == MODE_SCAN) begin
          if (!dir) begin
            pos <= pos + 3'd1;
            if (pos == POS_NEAR) dir <= 1'b1;
          end else begin
            pos <= pos - 3'd1;
            if (pos == 3'd1) dir <= 1'b0;
          end
        end
      end

      scan_end <= end_hit;
      if (end_hit)        end_flag <= 1'b1;
      else if (rd_status) end_flag <= 1'b0;

      led_out <= pattern & {NUM_LEDS{pwm_on}};
      in_port <= rd_mux;
    end
  end

  logic unused_top;
  assign unused_top = ^POS_TOP;
endmodule

// File: tb/tb_kcpsm6_led_scanner.sv
// tb/tb_kcpsm6_led_scanner.sv - directed/randomised bench for kcpsm6_led_scanner.
// Reference model derives LED state from elapsed clocks since the last CTRL write.
module tb_kcpsm6_led_scanner;
  localparam int         N    = 4;
  localparam logic [7:0] BASE = 8'h10;
  localparam int         CPU  = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   port_id = 8'h00;
  logic         write_strobe = 1'b0;
  logic [7:0]   out_port = 8'h00;
  logic         read_strobe = 1'b0;
  logic [7:0]   in_port;
  logic [N-1:0] led_out;
  logic         scan_end;

  int         checks = 0;
  int         failures = 0;
  int         m = 0;
  bit         track = 0;
  logic [7:0] md_data = 8'h00;
  logic [7:0] md_period = 8'h00;
  logic [1:0] md_mode = 2'd0;
  logic [7:0] md_bright = 8'hFF;
  logic [7:0] pwm_ref = 8'h00;
  logic [7:0] rnd;
  logic [7:0] old_data;
  int         on_count;

  always #5 clk = ~clk;

  // Free-running brightness counter as seen from the LED outputs.
  always @(posedge clk or negedge reset) begin
    if (!reset) pwm_ref <= 8'h00;
    else        pwm_ref <= pwm_ref + 8'd1;
  end

  kcpsm6_led_scanner #(
    .NUM_LEDS(N),
    .BASE_ADDR(BASE),
    .CLKS_PER_UNIT(CPU)
  ) dut (
    .clk(clk),
    .reset(reset),
    .port_id(port_id),
    .write_strobe(write_strobe),
    .out_port(out_port),
    .read_strobe(read_strobe),
    .in_port(in_port),
    .led_out(led_out),
    .scan_end(scan_end)
  );

  function automatic int step_len();
    return CPU * (int'(md_period) + 1);
  endfunction

  function automatic int steps_done();
    return (m >= 1) ? (m - 1) / step_len() : 0;
  endfunction

  function automatic int tri_pos(input int n);
    int r;
    r = n % (2 * (N - 1));
    return (r <= N - 1) ? r : 2 * (N - 1) - r;
  endfunction

  function automatic logic [N-1:0] exp_led_d(input logic [7:0] d);
    logic [N-1:0] p;
    logic [N-1:0] one;
    logic [7:0]   pv;
    int           n;
    n   = steps_done();
    one = 1;
    case (md_mode)
      2'd0:    p = d[N-1:0];
      2'd1:    p = (n % 2 == 1) ? d[N-1:0] : '0;
      2'd2:    p = one << tri_pos(n);
      default: p = '0;
    endcase
    pv = pwm_ref - 8'd1;
`ifdef LED_PWM_EN
    if (!(pv < md_bright)) p = '0;
`endif
    return p;
  endfunction

  function automatic logic exp_end();
    int s;
    s = step_len();
    if (md_mode != 2'd2 || m < 1 || (m % s) != 0) return 1'b0;
    return (tri_pos(m / s) == 0) || (tri_pos(m / s) == N - 1);
  endfunction

  function automatic logic [7:0] exp_status_masked();
    logic [2:0] p;
    logic       d;
    logic       ph;
    int         n;
    n  = steps_done();
    p  = 3'd0;
    d  = 1'b0;
    ph = 1'b0;
    if (md_mode == 2'd2) begin
      p = 3'(tri_pos(n));
      d = ((n % (2 * (N - 1))) >= N - 1);
    end
    if (md_mode == 2'd1) ph = (n % 2 == 1);
    return {p, d, ph, 1'b0, md_mode};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    m++;
    if (track) begin
      check8("led_out", 8'(led_out), 8'(exp_led_d(md_data)));
      check8("scan_end", 8'(scan_end), 8'(exp_end()));
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    port_id      = a;
    out_port     = d;
    write_strobe = 1'b1;
    @(posedge clk);
    #1;
    write_strobe = 1'b0;
    m++;
    if (a == BASE)         md_data = d;
    if (a == BASE + 8'd2)  md_period = d;
    if (a == BASE + 8'd1) begin
      md_mode = d[1:0];
      m = 0;
    end
`ifdef LED_PWM_EN
    if (a == BASE + 8'd4)  md_bright = d;
`endif
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    port_id = a;
    cyc();
    check8(tag, in_port, exp);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check8("rst_led", 8'(led_out), 8'h00);
    check8("rst_scan_end", 8'(scan_end), 8'h00);
    check8("rst_in_port", in_port, 8'h00);
    reset = 1'b1;
    for (int a = 0; a < 5; a++) rd(BASE + 8'(a), 8'h00, "rst_readback");
    track = 1;

    // Direct mode, write-to-LED latency, readback
    for (int i = 0; i < 4; i++) begin
      rnd      = 8'($urandom);
      old_data = md_data;
      wr(BASE, rnd);
      check8("latency_1clk", 8'(led_out), 8'(exp_led_d(old_data)));
      wr(BASE + 8'd1, 8'h00);
      check8("latency_2clk", 8'(led_out), 8'(exp_led_d(rnd)));
      rd(BASE, rnd, "data_readback");
    end
    wr(BASE, 8'hA5);
    wr(BASE + 8'd1, 8'h00);
    check8("direct_a5", 8'(led_out), 8'h05);
    wr(BASE + 8'd1, 8'hFF);
    rd(BASE + 8'd1, 8'h03, "ctrl_upper_zero");
    repeat (3) cyc();
    wr(BASE + 8'd1, 8'h00);
    rnd = 8'($urandom);
    wr(BASE + 8'd2, rnd);
    rd(BASE + 8'd2, rnd, "period_readback");
    rd(BASE + 8'd5 + 8'($urandom_range(0, 200)), 8'h00, "unmapped");
    wr(BASE + 8'd2, 8'h00);

    // Scan mode: first with PERIOD=1, then random periods
    for (int k = 0; k < 3; k++) begin
      wr(BASE + 8'd2, (k == 0) ? 8'd1 : 8'($urandom_range(0, 3)));
      wr(BASE + 8'd1, 8'h02);
      port_id = BASE + 8'd3;
      for (int i = 0; i < 2 * (N - 1) * step_len() + 3; i++) begin
        cyc();
        check8("status", in_port & 8'hFB, exp_status_masked());
      end
    end

    // Sticky end flag: read clears, a set on the read cycle wins
    wr(BASE + 8'd2, 8'd1);
    wr(BASE + 8'd1, 8'h02);
    port_id = BASE + 8'd3;
    while (m < 30) cyc();
    read_strobe = 1'b1;
    cyc();
    read_strobe = 1'b0;
    check8("end_flag_set", 8'(in_port[2]), 8'h01);
    cyc();
    check8("end_flag_cleared", 8'(in_port[2]), 8'h00);
    while (m < 47) cyc();
    read_strobe = 1'b1;
    cyc();
    read_strobe = 1'b0;
    check8("end_on_read_cycle", 8'(scan_end), 8'h01);
    check8("flag_before_set", 8'(in_port[2]), 8'h00);
    cyc();
    check8("set_wins", 8'(in_port[2]), 8'h01);

    // Blink mode, then a CTRL rewrite mid-period restarts the phase
    wr(BASE, 8'h0F);
    wr(BASE + 8'd2, 8'h00);
    wr(BASE + 8'd1, 8'h01);
    port_id = BASE + 8'd3;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check8("blink_status", in_port & 8'hFB, exp_status_masked());
    end
    while (m < 6) cyc();
    wr(BASE, 8'($urandom));
    wr(BASE + 8'd1, 8'h01);
    for (int i = 0; i < 16; i++) cyc();

    // Reset in the middle of a scan
    wr(BASE + 8'd2, 8'h00);
    wr(BASE + 8'd1, 8'h02);
    while (m < 13) cyc();
    reset = 1'b0;
    #2;
    check8("midrst_led", 8'(led_out), 8'h00);
    check8("midrst_scan_end", 8'(scan_end), 8'h00);
    check8("midrst_in_port", in_port, 8'h00);
    md_data   = 8'h00;
    md_period = 8'h00;
    md_mode   = 2'd0;
    md_bright = 8'hFF;
    @(negedge clk);
    reset = 1'b1;
    m = 0;
    rd(BASE + 8'd3, 8'h00, "status_after_reset");

    // Brightness register
`ifdef LED_PWM_EN
    wr(BASE + 8'd4, 8'h40);
    wr(BASE, 8'h0F);
    wr(BASE + 8'd1, 8'h00);
    rd(BASE + 8'd4, 8'h40, "bright_readback");
    on_count = 0;
    for (int i = 0; i < 256; i++) begin
      cyc();
      if (led_out == 4'hF) on_count++;
    end
    check8("pwm_on_cycles", 8'(on_count), 8'd64);
`else
    wr(BASE + 8'd4, 8'h5A);
    rd(BASE + 8'd4, 8'h00, "bright_absent");
    on_count = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
